rv32_decode_issue_stage: RTL and testbench
==========================================

# rv32_decode_issue_stage

Parametrised decode stage for the rv32 pipeline, sitting between the fetch buffer and the execute stage. It reads the register file and decodes register usage. It resolves forwarding against a configurable number of downstream producers, inserts load-use bubbles, and passes one instruction per cycle through a valid/ready pipeline register. A flush replaces the in-flight slot with a NOP.

## Interface
Parameters:
- NUM_FWD, 2, number of downstream forwarding sources checked (index 0 = youngest/highest priority)
- RESET_PC, 32'h0, out_pc value after reset
- BYP_W, $clog2(NUM_FWD+1), width of bypass select codes (derived, not overridden)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decode accepts this cycle
- in_pc  in  32  PC of offered instruction
- in_instr  in  32  offered instruction word
- flush  in  1  squash in-flight slot, emit NOP
- flush_pc  in  32  PC tagged on the flush NOP
- rs1_id, rs2_id  out  5 each  register-file read addresses = in_instr[19:15], [24:20]
- rs1_data, rs2_data  in  32 each  register-file read data, same cycle
- fwd_valid  in  NUM_FWD  producer i holds a live write
- fwd_rd  in  5*NUM_FWD  destination of producer i, slice [5i+4:5i]
- fwd_is_load  in  NUM_FWD  producer i result not yet available
- out_valid  out  1  decoded slot valid
- out_ready  in  1  execute accepts slot
- out_pc, out_instr, out_reg1, out_reg2  out  32 each  registered slot contents
- out_use_rs  out  2  bit0 = rs1 used, bit1 = rs2 used
- out_byp1, out_byp2  out  BYP_W each  0 = register file, i+1 = forward from producer i
- stall_cycles  out  32  load-use stall count (STALL_PERF_EN only)

## Operation
- use_rs from opcode in_instr[6:0]: rs1 used except LUI 0110111, AUIPC 0010111, JAL 1101111. rs2 used for BRANCH 1100011, STORE 0100011, OP 0110011. Both bits 0 for unknown opcodes.
- Source match for rsN: used bit set, rsN != 0, fwd_valid[i], fwd_rd[i] == rsN. The lowest matching i wins, giving byp = i+1. No match gives byp = 0.
- Hazard when the winning match for either source has fwd_is_load[i] = 1.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready): the slot loads pc, instr, rs1_data, rs2_data, use_rs and byp codes, and out_valid goes to 1.
- Drain without accept (out_valid & out_ready & !accept): out_valid goes to 0, and a bubble goes downstream.
- While out_valid & !out_ready, all out_* hold stable.
- Flush has priority over everything. Next cycle: out_valid=1, out_instr=32'h00000013, out_pc=flush_pc, reg/byp/use_rs=0. The offered instruction is not accepted.
- A slot overwritten by flush while stalled downstream is discarded. Execute must treat flush as a squash.

## Timing
- Latency 1 cycle from accept to out_valid. Throughput 1/cycle with no hazards.
- Reset values: out_valid=0, out_instr=32'h00000013, out_pc=RESET_PC, out_reg1/2=0, out_byp1/2=0, out_use_rs=0, stall_cycles=0.
- in_ready and rs*_id are combinational from inputs and current out_valid. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-stall or mid-flush clears state immediately. in_ready then follows the formula with out_valid=0.
- Hazard and flush in the same cycle: flush wins, and no stall cycle is counted.

## Configuration
- STALL_PERF_EN defined: stall_cycles increments by 1 each cycle with in_valid & hazard & !flush. It saturates at 32'hFFFFFFFF and is cleared only by reset.
- STALL_PERF_EN undefined: stall_cycles is tied to 0 and no counter register exists.

## Test plan
- Back-to-back ADDs x1..x4, out_ready=1, no forwarding → one out_valid per cycle, 1-cycle latency, byp=0, regs equal to register-file data.
- rs1=x5, fwd_valid=2'b11, fwd_rd={x5,x5}, is_load=0 → out_byp1=1 (producer 0 wins). Same case with rd=x0 → byp=0.
- Load-use: rs2=x7 matched by producer 1 with is_load=1 for 3 cycles, then is_load=0 → in_ready=0 for 3 cycles, out_valid=0 bubbles, then accept with out_byp2=2. stall_cycles=3 with STALL_PERF_EN.
- out_ready=0 for 4 cycles with out_valid=1 → out_* unchanged, in_ready=0. On release, the next instruction issues the following cycle.
- flush with flush_pc=32'h80 during downstream stall → next cycle out_instr=32'h00000013, out_pc=32'h80, out_valid=1. The offered instruction is held, not lost.
- Assert reset mid-stream → out_valid=0 and out_pc=RESET_PC immediately without a clock edge.

Source files
------------

// File: rtl/rv32_decode_issue_stage.sv
// rv32 decode/issue: register read, forwarding select, load-use stall, flush NOP.
// Define STALL_PERF_EN to add a saturating load-use stall counter.
module rv32_decode_issue_stage #(
    parameter int          NUM_FWD  = 2,
    parameter logic [31:0] RESET_PC = 32'h0,
    localparam int         BYP_W    = $clog2(NUM_FWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic                 flush,
    input  logic [31:0]          flush_pc,
    output logic [4:0]           rs1_id,
    output logic [4:0]           rs2_id,
    input  logic [31:0]          rs1_data,
    input  logic [31:0]          rs2_data,
    input  logic [NUM_FWD-1:0]   fwd_valid,
    input  logic [5*NUM_FWD-1:0] fwd_rd,
    input  logic [NUM_FWD-1:0]   fwd_is_load,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_reg1,
    output logic [31:0]          out_reg2,
    output logic [1:0]           out_use_rs,
    output logic [BYP_W-1:0]     out_byp1,
    output logic [BYP_W-1:0]     out_byp2,
    output logic [31:0]          stall_cycles
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [31:0] NOP       = 32'h00000013;

    logic [1:0]       use_rs;
    logic [BYP_W-1:0] byp1;
    logic [BYP_W-1:0] byp2;
    logic             ld1;
    logic             ld2;
    logic             hazard;
    logic             accept;

    assign rs1_id = in_instr[19:15];
    assign rs2_id = in_instr[24:20];

    always_comb begin
        use_rs = 2'b00;
        unique case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL:     use_rs = 2'b00;
            OPC_JALR, OPC_LOAD, OPC_OPIMM:   use_rs = 2'b01;
            OPC_BRANCH, OPC_STORE, OPC_OP:   use_rs = 2'b11;
            default:                         use_rs = 2'b00;
        endcase
    end

    // Walk from oldest to youngest so the lowest matching index wins.
    always_comb begin
        byp1 = '0;
        byp2 = '0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (use_rs[0] && rs1_id != 5'd0 && fwd_valid[i]
                && fwd_rd[5*i +: 5] == rs1_id) begin
                byp1 = BYP_W'(i + 1);
                ld1  = fwd_is_load[i];
            end
            if (use_rs[1] && rs2_id != 5'd0 && fwd_valid[i]
                && fwd_rd[5*i +: 5] == rs2_id) begin
                byp2 = BYP_W'(i + 1);
                ld2  = fwd_is_load[i];
            end
        end
    end

    assign hazard   = ld1 | ld2;
    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_pc     <= RESET_PC;
            out_instr  <= NOP;
            out_reg1   <= '0;
            out_reg2   <= '0;
            out_use_rs <= '0;
            out_byp1   <= '0;
            out_byp2   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b1;
            out_pc     <= flush_pc;
            out_instr  <= NOP;
            out_reg1   <= '0;
            out_reg2   <= '0;
            out_use_rs <= '0;
            out_byp1   <= '0;
            out_byp2   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_pc     <= in_pc;
            out_instr  <= in_instr;
            out_reg1   <= rs1_data;
            out_reg2   <= rs2_data;
            out_use_rs <= use_rs;
            out_byp1   <= byp1;
            out_byp2   <= byp2;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else if (in_valid && hazard && !flush && stall_q != '1) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_rv32_decode_issue_stage.sv
// Self-checking bench for rv32_decode_issue_stage: directed plan steps
// followed by randomized traffic against a behavioural model.
module tb_rv32_decode_issue_stage;

    localparam int          NF   = 2;
    localparam logic [31:0] RPC  = 32'h0;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic [31:0] flush_pc;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [NF-1:0]   fwd_valid;
    logic [5*NF-1:0] fwd_rd;
    logic [NF-1:0]   fwd_is_load;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_reg1;
    logic [31:0] out_reg2;
    logic [1:0]  out_use_rs;
    logic [1:0]  out_byp1;
    logic [1:0]  out_byp2;
    logic [31:0] stall_cycles;

    logic [31:0] rf [32];
    int total = 0;
    int bad = 0;

    // model state
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_r1, m_r2, m_stall;
    logic [1:0]  m_use;
    int          m_b1, m_b2;

    rv32_decode_issue_stage #(.NUM_FWD(NF), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush), .flush_pc(flush_pc),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_is_load(fwd_is_load),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .out_reg1(out_reg1), .out_reg2(out_reg2),
        .out_use_rs(out_use_rs),
        .out_byp1(out_byp1), .out_byp2(out_byp2),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign rs1_data = rf[in_instr[19:15]];
    assign rs2_data = rf[in_instr[24:20]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input int rd, input int a,
                                         input int b, input logic [6:0] opc);
        logic [31:0] w;
        w = {7'b0, 5'(b), 5'(a), 3'b000, 5'(rd), opc};
        return w;
    endfunction

    // Register usage straight from the opcode table.
    function automatic logic [1:0] f_use(input logic [31:0] ins);
        case (ins[6:0])
            7'b1100111, 7'b0000011, 7'b0010011: return 2'b01;
            7'b1100011, 7'b0100011, 7'b0110011: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int f_byp(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 0;
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_rd[5*i +: 5] == rs) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_pc = RPC; m_instr = NOP;
        m_r1 = '0; m_r2 = '0; m_use = '0; m_b1 = 0; m_b2 = 0;
        m_stall = '0;
    endtask

    task automatic check_slot();
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("stall_cycles", stall_cycles, m_stall);
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_instr", out_instr, m_instr);
            chk("out_reg1", out_reg1, m_r1);
            chk("out_reg2", out_reg2, m_r2);
            chk("out_use_rs", {30'b0, out_use_rs}, {30'b0, m_use});
            chk("out_byp1", {30'b0, out_byp1}, 32'(m_b1));
            chk("out_byp2", {30'b0, out_byp2}, 32'(m_b2));
        end
    endtask

    // Called at posedge+1 with inputs already driven; ends at posedge+1.
    task automatic step();
        logic [1:0] u;
        int b1, b2;
        logic haz, rdy, acc;
        #2;
        u   = f_use(in_instr);
        b1  = f_byp(in_instr[19:15], u[0]);
        b2  = f_byp(in_instr[24:20], u[1]);
        haz = (b1 != 0 && fwd_is_load[b1-1]) || (b2 != 0 && fwd_is_load[b2-1]);
        rdy = !flush && !haz && (!m_valid || out_ready);
        acc = in_valid && rdy;
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
        chk("rs1_id", {27'b0, rs1_id}, {27'b0, in_instr[19:15]});
        chk("rs2_id", {27'b0, rs2_id}, {27'b0, in_instr[24:20]});
        @(posedge clk);
`ifdef STALL_PERF_EN
        if (in_valid && haz && !flush && m_stall != 32'hFFFFFFFF) m_stall++;
`endif
        if (flush) begin
            m_valid = 1'b1; m_pc = flush_pc; m_instr = NOP;
            m_r1 = '0; m_r2 = '0; m_use = '0; m_b1 = 0; m_b2 = 0;
        end else if (acc) begin
            m_valid = 1'b1; m_pc = in_pc; m_instr = in_instr;
            m_r1 = rf[in_instr[19:15]]; m_r2 = rf[in_instr[24:20]];
            m_use = u; m_b1 = b1; m_b2 = b2;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_slot();
    endtask

    logic [6:0] opc_tab [11];
    logic [31:0] held;

    initial begin
        opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                    7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                    7'b0110011, 7'b1110011, 7'b0001111};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = NOP;
        flush = 1'b0; flush_pc = '0; fwd_valid = '0; fwd_rd = '0;
        fwd_is_load = '0; out_ready = 1'b1;
        model_reset();
        #1;
        check_slot();
        chk("reset_instr", out_instr, NOP);
        chk("reset_pc", out_pc, RPC);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // back-to-back ADDs x1..x4
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_pc = 32'h100 + 32'(4 * k);
            in_instr = r_op(k, k + 8, k + 12, 7'b0110011);
            step();
            chk("add_valid", {31'b0, out_valid}, 32'd1);
            chk("add_instr", out_instr, in_instr);
            chk("add_reg1", out_reg1, rf[k + 8]);
            chk("add_byp1", {30'b0, out_byp1}, 32'd0);
        end

        // youngest producer wins; x0 never forwards
        in_instr = r_op(9, 5, 0, 7'b0110011);
        fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5};
        step();
        chk("fwd_prio_byp1", {30'b0, out_byp1}, 32'd1);
        in_instr = r_op(0, 0, 0, 7'b0110011);
        fwd_rd = {5'd0, 5'd0};
        step();
        chk("fwd_x0_byp1", {30'b0, out_byp1}, 32'd0);

        // load-use on rs2 via producer 1
        in_instr = r_op(3, 1, 7, 7'b0110011);
        fwd_valid = 2'b10; fwd_rd = {5'd7, 5'd0}; fwd_is_load = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("lu_ready", {31'b0, in_ready}, 32'd0);
            chk("lu_bubble", {31'b0, out_valid}, 32'd0);
        end
        fwd_is_load = 2'b00;
        step();
        chk("lu_issue", {31'b0, out_valid}, 32'd1);
        chk("lu_byp2", {30'b0, out_byp2}, 32'd2);
`ifdef STALL_PERF_EN
        chk("lu_stall_cnt", stall_cycles, 32'd3);
`else
        chk("lu_stall_cnt", stall_cycles, 32'd0);
`endif
        fwd_valid = '0;

        // downstream backpressure
        held = out_instr;
        in_instr = r_op(4, 2, 3, 7'b0110011);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_hold", out_instr, held);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", out_instr, in_instr);

        // flush while execute is stalled
        out_ready = 1'b0; flush = 1'b1; flush_pc = 32'h80;
        in_instr = r_op(6, 1, 2, 7'b0110011); in_pc = 32'h200;
        step();
        chk("fl_instr", out_instr, NOP);
        chk("fl_pc", out_pc, 32'h80);
        chk("fl_valid", {31'b0, out_valid}, 32'd1);
        flush = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_held_issue", out_instr, in_instr);

        // asynchronous reset mid-stream
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_pc", out_pc, RPC);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_slot();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            in_pc       = $urandom;
            in_instr    = r_op($urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 7),
                               opc_tab[$urandom_range(0, 10)]);
            in_instr[14:12] = 3'($urandom);
            fwd_valid   = NF'($urandom);
            fwd_rd      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_is_load = NF'($urandom) & NF'($urandom);
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            flush_pc    = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
